// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling, one-cycle recv_valid strobe with held data.
// Optional stop-bit check, BREAK state and frame_err pulse under `define UART_RX_FRAME_CHECK_EN.
module uart_rx_ctrl #(
    parameter logic [13:0] TMR_MAX  = 14'd10416,
    parameter logic [13:0] HALF_MAX = 14'd5207
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       UART_RX,
    output logic [7:0] recv_data,
    output logic       recv_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        rx_s1, rx_s2;
    logic [13:0] timer, timer_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
`ifdef UART_RX_FRAME_CHECK_EN
    logic        ferr_nxt;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            shreg      <= '0;
            recv_data  <= '0;
            recv_valid <= 1'b0;
        end else begin
            rx_s1      <= UART_RX;
            rx_s2      <= rx_s1;
            state      <= state_nxt;
            timer      <= timer_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            recv_data  <= data_nxt;
            recv_valid <= valid_nxt;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) frame_err <= 1'b0;
        else       frame_err <= ferr_nxt;
    end
`else
    assign frame_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = recv_data;
        valid_nxt = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        ferr_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (!rx_s2) state_nxt = START;
            end
            // A start bit must still be low at its mid-point, otherwise it was a glitch.
            START: begin
                if (timer == HALF_MAX) begin
                    timer_nxt = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s2 ? IDLE : DATA;
                end else begin
                    timer_nxt = timer + 14'd1;
                end
            end
            DATA: begin
                if (timer == TMR_MAX) begin
                    timer_nxt = '0;
                    shreg_nxt = {rx_s2, shreg[7:1]};
                    idx_nxt   = idx + 4'd1;
                    if (idx == 4'd7) state_nxt = STOP;
                end else begin
                    timer_nxt = timer + 14'd1;
                end
            end
            // Returning to IDLE at mid-stop lets a back-to-back start edge be caught with no dead time.
            STOP: begin
                if (timer == TMR_MAX) begin
                    timer_nxt = '0;
`ifdef UART_RX_FRAME_CHECK_EN
                    if (rx_s2) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
`else
                    data_nxt  = shreg;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
`endif
                end else begin
                    timer_nxt = timer + 14'd1;
                end
            end
`ifdef UART_RX_FRAME_CHECK_EN
            BREAK: begin
                timer_nxt = '0;
                if (rx_s2) state_nxt = IDLE;
            end
`endif
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a 16-cycle bit period (TMR_MAX=15, HALF_MAX=7).
// Table of single frames plus hand-written multi-cycle sequences; works with or without UART_RX_FRAME_CHECK_EN.
module tb_uart_rx_ctrl;

    localparam logic [13:0] TMR  = 14'd15;
    localparam logic [13:0] HALF = 14'd7;
    localparam int BIT      = 16;
    localparam int LATENCY  = 3 + 8 + 9 * 16;   // pin fall to sampled recv_valid: sync + start check + 9 bits
    localparam int B2B_GAP  = 10 * 16;
    localparam int GLITCH_BUSY = 8;            // START lasts HALF_MAX+1 cycles

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_ctrl #(.TMR_MAX(TMR), .HALF_MAX(HALF)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .UART_RX    (UART_RX),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         n_busy = 0;
    int         n_ferr = 0;
    int         n_both = 0;
    int         vq_cyc[$];
    logic [7:0] vq_data[$];

    always @(negedge CLK) begin
        if (busy) n_busy++;
        if (frame_err) n_ferr++;
        if (recv_valid && frame_err) n_both++;
        if (recv_valid) begin
            vq_cyc.push_back(cyc);
            vq_data.push_back(recv_data);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int fall_cyc = 0;
    int b_busy, b_ferr, b_vld;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic mark();
        b_busy = n_busy;
        b_ferr = n_ferr;
        b_vld  = vq_data.size();
    endtask

    function automatic int new_valids();
        return vq_data.size() - b_vld;
    endfunction

    function automatic int nth_data(input int k);
        if (vq_data.size() > b_vld + k) return int'(vq_data[b_vld + k]);
        return -1;
    endfunction

    function automatic int nth_cyc(input int k);
        if (vq_cyc.size() > b_vld + k) return vq_cyc[b_vld + k];
        return -1;
    endfunction

    // Caller is always 1 time unit after a rising edge.
    task automatic hold(input logic lvl, input int n);
        UART_RX = lvl;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b);
        fall_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b);
        hold(1'b1, BIT);
    endtask

    typedef struct {
        logic [7:0] tx;
        int         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{tx: 8'h55, exp_valid: 1, exp_data: 8'h55};
        vecs[1] = '{tx: 8'h00, exp_valid: 1, exp_data: 8'h00};
        vecs[2] = '{tx: 8'hFF, exp_valid: 1, exp_data: 8'hFF};
        vecs[3] = '{tx: 8'h96, exp_valid: 1, exp_data: 8'h96};
        vecs[4] = '{tx: 8'h01, exp_valid: 1, exp_data: 8'h01};
        vecs[5] = '{tx: 8'h80, exp_valid: 1, exp_data: 8'h80};

        // Reset and idle line
        @(posedge CLK); #1;
        RSTN = 1'b0;
        hold(1'b1, 3);
        RSTN = 1'b1;
        check("reset_data", recv_data, 8'h00);
        check("reset_valid", recv_valid, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_busy", busy, 0);
        mark();
        hold(1'b1, 100);
        check("idle_busy_cycles", n_busy - b_busy, 0);
        check("idle_valids", new_valids(), 0);
        check("idle_ferr", n_ferr - b_ferr, 0);
        check("idle_data", recv_data, 8'h00);

        // Single frames from the table
        for (int v = 0; v < 6; v++) begin
            mark();
            send_frame(vecs[v].tx);
            hold(1'b1, 40);
            check($sformatf("vec%0d_valid_count", v), new_valids(), vecs[v].exp_valid);
            check($sformatf("vec%0d_pulse_data", v), nth_data(0), vecs[v].exp_data);
            check($sformatf("vec%0d_held_data", v), recv_data, vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), n_ferr - b_ferr, 0);
            check($sformatf("vec%0d_busy_end", v), busy, 0);
            if (v == 0) check("vec0_latency", nth_cyc(0) - fall_cyc, LATENCY);
        end

        // Back-to-back frames, no idle gap
        mark();
        send_frame(8'hA3);
        send_frame(8'h0F);
        hold(1'b1, 40);
        check("b2b_valid_count", new_valids(), 2);
        check("b2b_data0", nth_data(0), 8'hA3);
        check("b2b_data1", nth_data(1), 8'h0F);
        check("b2b_spacing", nth_cyc(1) - nth_cyc(0), B2B_GAP);

        // Short low glitch on an idle line
        mark();
        hold(1'b0, 4);
        hold(1'b1, 30);
        check("glitch_busy_cycles", n_busy - b_busy, GLITCH_BUSY);
        check("glitch_valids", new_valids(), 0);
        check("glitch_ferr", n_ferr - b_ferr, 0);
        check("glitch_data", recv_data, 8'h0F);

        // Bad stop bit followed by a held-low line
        mark();
        send_bits(8'h3C);
        hold(1'b0, 300);
`ifdef UART_RX_FRAME_CHECK_EN
        check("brk_busy_low", busy, 1);
        hold(1'b1, 40);
        check("brk_ferr_count", n_ferr - b_ferr, 1);
        check("brk_valids", new_valids(), 0);
        check("brk_data_kept", recv_data, 8'h0F);
        check("brk_busy_end", busy, 0);
`else
        hold(1'b1, 400);
        check("nochk_first_data", nth_data(0), 8'h3C);
        check("nochk_valid_seen", (new_valids() >= 1) ? 1 : 0, 1);
        check("nochk_ferr", n_ferr - b_ferr, 0);
`endif

        // Reset during data bit 4, then a clean frame
        mark();
        fall_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(1'b0, BIT);
        hold(1'b1, BIT / 2);
        RSTN = 1'b0;
        hold(1'b1, 3);
        RSTN = 1'b1;
        check("rstmid_data", recv_data, 8'h00);
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", recv_valid, 0);
        check("rstmid_ferr", frame_err, 0);
        hold(1'b1, 40);
        check("rstmid_no_pulse", new_valids() + (n_ferr - b_ferr), 0);
        mark();
        send_frame(8'h81);
        hold(1'b1, 40);
        check("after_rst_valid_count", new_valids(), 1);
        check("after_rst_data", recv_data, 8'h81);
        check("after_rst_latency", nth_cyc(0) - fall_cyc, LATENCY);

        check("never_both_strobes", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
